// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin req/ack arbiter sharing one data RAM between two requesters
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   m0_* / m1_*                 requester ports: req/we/addr/wdata in, ack/err/rdata out
//                               (ack is a one-cycle pulse; err/rdata valid with ack)
//   ram_we_o, ram_addr_o,       RAM write enable, byte address and write data
//   ram_wdata_o
//   ram_rdata_i                 RAM combinational read data
module ram_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [DATA_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [DATA_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);
  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(4 * MEMORY_DEPTH);
  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, win, we_l, valid_l;
  logic [DATA_WIDTH-1:0] addr_l, wdata_l;
  logic any_req, sel, sel_we, sel_valid;
  logic [DATA_WIDTH-1:0] sel_addr, sel_wdata, sel_off, rd_data;
  always_comb begin
    any_req = m0_req_i | m1_req_i;
    // on a tie the port that did not win last time gets the grant
    sel = (m0_req_i & m1_req_i) ? ~last_grant : m1_req_i;
    sel_we = sel ? m1_we_i : m0_we_i;
    sel_addr = sel ? m1_addr_i : m0_addr_i;
    sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
    // the >= guard keeps addresses below the base from wrapping into range
    sel_off = sel_addr - BASE_ADDR;
    sel_valid = (sel_addr[1:0] == 2'b00) && (sel_addr >= BASE_ADDR) && (sel_off < SPAN);
    rd_data = (~we_l & valid_l) ? ram_rdata_i : '0;
    state_nx = (state == IDLE) ? (any_req ? GRANT : IDLE) : (state == GRANT) ? RESP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      win <= 1'b0;
      we_l <= 1'b0;
      valid_l <= 1'b0;
      addr_l <= BASE_ADDR;
      wdata_l <= '0;
      m0_err_o <= 1'b0;
      m0_rdata_o <= '0;
      m1_err_o <= 1'b0;
      m1_rdata_o <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        win <= sel;
        we_l <= sel_we;
        addr_l <= sel_addr;
        wdata_l <= sel_wdata;
        valid_l <= sel_valid;
        last_grant <= sel;
      end
      // response data is captured at the end of GRANT and held until the port's next ack
      if (state == GRANT) begin
        if (win) begin
          m1_err_o <= ~valid_l;
          m1_rdata_o <= rd_data;
        end else begin
          m0_err_o <= ~valid_l;
          m0_rdata_o <= rd_data;
        end
      end
    end
  end
  // a reset arriving mid-transaction must not leak a write or an ack
  assign ram_we_o = (state == GRANT) & we_l & valid_l & ~rst;
  assign ram_addr_o = (state == GRANT) ? addr_l : BASE_ADDR;
  assign ram_wdata_o = (state == GRANT) ? wdata_l : '0;
  assign m0_ack_o = (state == RESP) & ~win & ~rst;
  assign m1_ack_o = (state == RESP) & win & ~rst;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: randomized self-checking bench with a transaction-level model
module tb_ram_access_arbiter;
  localparam logic [31:0] BASE = 32'h1001_0000;
  logic clk = 1'b0;
  logic rst;
  logic m0_req_i, m0_we_i, m0_ack_o, m0_err_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic m1_req_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [31:0] tb_ram [64];
  logic [31:0] ref_mem [64];
  bit fill_done;
  bit last_g;
  int checks = 0;
  int failures = 0;

  ram_access_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic bit valid_m(input logic [31:0] a);
    longint la = longint'(a);
    return (a[1:0] == 2'b00) && (la >= longint'(BASE)) && (la <= longint'(BASE) + 64'd252);
  endfunction

  function automatic int idx(input logic [31:0] a);
    logic [31:0] d = a - BASE;
    return int'(d[7:2]);
  endfunction

  function automatic logic [31:0] pat(input int i);
    return 32'hA55A_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  always @(posedge clk) begin
    if (!fill_done) begin
      for (int i = 0; i < 64; i++) tb_ram[i] <= pat(i);
      fill_done <= 1'b1;
    end else if (ram_we_o) tb_ram[idx(ram_addr_o)] <= ram_wdata_o;
  end

  assign ram_rdata_i = valid_m(ram_addr_o) ? tb_ram[idx(ram_addr_o)] : 32'hBADC_0FFE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic e, output logic [31:0] r, inout int nw);
    bit v = valid_m(a);
    e = !v;
    r = (v && !we) ? ref_mem[idx(a)] : 32'h0;
    if (v && we) begin
      ref_mem[idx(a)] = d;
      nw++;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned s = $urandom_range(0, 9);
    if (s < 6) return BASE + 32'(4 * $urandom_range(0, 63));
    if (s == 6) return BASE + 32'($urandom_range(0, 255));
    if (s == 7) return BASE + 32'd256 + 32'(4 * $urandom_range(0, 3));
    if (s == 8) return BASE - 32'(4 * $urandom_range(1, 4));
    return $urandom;
  endfunction

  task automatic run(input bit en0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit en1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
    int at0 = 0, at1 = 0, n0 = 0, n1 = 0, wes = 0, exp_we = 0, first, t0, t1;
    logic err0 = 1'b0, err1 = 1'b0, eerr0 = 1'b0, eerr1 = 1'b0;
    logic [31:0] rd0 = '0, rd1 = '0, erd0 = '0, erd1 = '0;
    @(negedge clk);
    m0_req_i = en0; m0_we_i = we0; m0_addr_i = a0; m0_wdata_i = d0;
    m1_req_i = en1; m1_we_i = we1; m1_addr_i = a1; m1_wdata_i = d1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (ram_we_o) wes++;
      if (m0_ack_o) begin
        n0++; at0 = k; err0 = m0_err_o; rd0 = m0_rdata_o; m0_req_i = 1'b0;
      end
      if (m1_ack_o) begin
        n1++; at1 = k; err1 = m1_err_o; rd1 = m1_rdata_o; m1_req_i = 1'b0;
      end
    end
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    first = (en0 && en1) ? (last_g ? 0 : 1) : (en1 ? 1 : 0);
    if (first == 0) begin
      if (en0) model(we0, a0, d0, eerr0, erd0, exp_we);
      if (en1) model(we1, a1, d1, eerr1, erd1, exp_we);
    end else begin
      if (en1) model(we1, a1, d1, eerr1, erd1, exp_we);
      if (en0) model(we0, a0, d0, eerr0, erd0, exp_we);
    end
    t0 = (en0 && en1 && first == 1) ? 5 : 2;
    t1 = (en0 && en1 && first == 0) ? 5 : 2;
    if (en0 && en1) last_g = (first == 0);
    else if (en0) last_g = 1'b0;
    else if (en1) last_g = 1'b1;
    chk("acks0", 32'(n0), 32'(en0));
    chk("acks1", 32'(n1), 32'(en1));
    if (en0) begin
      chk("lat0", 32'(at0), 32'(t0));
      chk("err0", 32'(err0), 32'(eerr0));
      chk("rdata0", rd0, erd0);
    end
    if (en1) begin
      chk("lat1", 32'(at1), 32'(t1));
      chk("err1", 32'(err1), 32'(eerr1));
      chk("rdata1", rd1, erd1);
    end
    chk("we_pulses", 32'(wes), 32'(exp_we));
  endtask

  task automatic fair();
    int n = 0, nw = 0;
    int exp_p = last_g ? 0 : 1;
    int first = exp_p;
    logic e0, e1;
    logic [31:0] r0, r1;
    @(negedge clk);
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = BASE + 32'd16; m0_wdata_i = '0;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = BASE + 32'd20; m1_wdata_i = '0;
    model(1'b0, BASE + 32'd16, 32'h0, e0, r0, nw);
    model(1'b0, BASE + 32'd20, 32'h0, e1, r1, nw);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (m0_ack_o || m1_ack_o) begin
        chk("fair_port", 32'(m1_ack_o), 32'(exp_p));
        chk("fair_both", 32'(m0_ack_o & m1_ack_o), 32'h0);
        chk("fair_time", 32'(k), 32'(2 + 3 * n));
        chk("fair_rdata", m1_ack_o ? m1_rdata_o : m0_rdata_o, exp_p == 1 ? r1 : r0);
        n++;
        exp_p = 1 - exp_p;
        if (n == 4) begin
          m0_req_i = 1'b0;
          m1_req_i = 1'b0;
        end
      end
    end
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    chk("fair_count", 32'(n), 32'd4);
    last_g = (first == 0);
  endtask

  task automatic reset_mid_grant();
    int acks = 0;
    @(negedge clk);
    m0_req_i = 1'b0;
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = BASE + 32'd8; m1_wdata_i = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    chk("grant_we", 32'(ram_we_o), 32'h1);
    chk("grant_addr", ram_addr_o, BASE + 32'd8);
    rst = 1'b1;
    m1_req_i = 1'b0;
    #1;
    chk("rst_we_gate", 32'(ram_we_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ack0", 32'(m0_ack_o), 32'h0);
    chk("rst_ack1", 32'(m1_ack_o), 32'h0);
    chk("rst_we", 32'(ram_we_o), 32'h0);
    chk("rst_addr", ram_addr_o, BASE);
    chk("rst_wdata", ram_wdata_o, 32'h0);
    chk("rst_err1", 32'(m1_err_o), 32'h0);
    chk("rst_rdata0", m0_rdata_o, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (m0_ack_o || m1_ack_o || ram_we_o) acks++;
    end
    chk("rst_quiet", 32'(acks), 32'h0);
    last_g = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    last_g = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_addr", ram_addr_o, BASE);
    chk("reset_we", 32'(ram_we_o), 32'h0);
    chk("reset_wdata", ram_wdata_o, 32'h0);
    chk("reset_acks", 32'({m0_ack_o, m1_ack_o}), 32'h0);
    chk("reset_errs", 32'({m0_err_o, m1_err_o}), 32'h0);
    chk("reset_rdata", m0_rdata_o | m1_rdata_o, 32'h0);
    rst = 1'b0;
    run(1'b1, 1'b0, BASE + 32'd8, 32'h0, 1'b1, 1'b0, BASE + 32'd12, 32'h0);
    fair();
    run(1'b1, 1'b1, BASE + 32'd4, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    run(1'b1, 1'b0, BASE + 32'd4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    run(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, BASE + 32'h100, 32'h0);
    run(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, BASE + 32'd2, 32'h1111_1111);
    run(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    run(1'b1, 1'b1, BASE + 32'hFC, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0);
    run(1'b1, 1'b0, BASE + 32'hFC, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset_mid_grant();
    run(1'b1, 1'b1, BASE + 32'd8, 32'h0BAD_CAFE, 1'b1, 1'b0, BASE + 32'd8, 32'h0);
    for (int t = 0; t < 200; t++) begin
      run($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (t % 50 == 49) fair();
    end
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk("mem", tb_ram[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
